// File: rtl/psum_drain_ctrl.sv
// psum_drain_ctrl: mode-2 partial-sum chaining sequencer between two PEs.
// Waits for the upstream PE to report ready_to_get, arms its output buffer,
// then moves num_psum psums (0 means 2^CNT_W) from the upstream output buffer
// into the downstream input-psum buffer, in order, one per cycle at best.
// A one-entry skid register (hold/hold_v) sits between the read and write
// sides so that a full downstream buffer never causes a psum to be lost.
// outbuf_dout is captured into hold on the clock edge that closes the cycle
// in which outbuf_ren is high, so the buffer's output register must already
// present the addressed word during that cycle.
// Optional feature macro: PSUM_DRAIN_SUM_EN adds sum_out, the running
// mod-2^DATA_W sum of every psum written downstream.
module psum_drain_ctrl #(
    parameter int DATA_W = 33,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_psum,
    input  logic              ready_to_get,
    input  logic              outbuf_empty,
    input  logic [DATA_W-1:0] outbuf_dout,
    output logic              outbuf_ren,
    output logic              outbuf_write_flag,
    input  logic              inpsum_buf_full,
    output logic              inpsum_buf_wen,
    output logic [DATA_W-1:0] inpsum_buf_inval,
    output logic              busy,
`ifdef PSUM_DRAIN_SUM_EN
    output logic [DATA_W-1:0] sum_out,
`endif
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] CNT_ZERO = {(CNT_W+1){1'b0}};
    localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};

    state_t              state_r;
    logic [CNT_W:0]      remaining_r;
    logic [CNT_W:0]      issued_r;
    logic [CNT_W:0]      written_r;
    logic [DATA_W-1:0]   hold_r;
    logic                hold_v_r;
    logic                flag_r;

    logic                ren_s;
    logic                wen_s;
    logic                last_s;

    // Read issue, downstream write and last-write detection for this cycle.
    always_comb begin
        ren_s  = 1'b0;
        wen_s  = hold_v_r && !inpsum_buf_full;
        last_s = wen_s && ((written_r + CNT_ONE) == remaining_r);
        if (state_r == DRAIN) begin
            // A read may only be issued when hold is free or is being freed
            // this same cycle, which keeps at most one psum in flight.
            ren_s = (issued_r < remaining_r) && !outbuf_empty &&
                    (!hold_v_r || wen_s);
        end else begin
            ren_s = 1'b0;
        end
    end

    // Sequencer state, skid register and transfer counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            remaining_r <= CNT_ZERO;
            issued_r    <= CNT_ZERO;
            written_r   <= CNT_ZERO;
            hold_r      <= {DATA_W{1'b0}};
            hold_v_r    <= 1'b0;
            flag_r      <= 1'b0;
        end else begin
            // A return and a write in the same cycle reload hold, keeping it valid.
            if (ren_s) begin
                hold_r   <= outbuf_dout;
                hold_v_r <= 1'b1;
            end else if (wen_s) begin
                hold_v_r <= 1'b0;
            end
            if (ren_s) begin
                issued_r <= issued_r + CNT_ONE;
            end
            if (wen_s) begin
                written_r <= written_r + CNT_ONE;
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        remaining_r <= (num_psum == {CNT_W{1'b0}}) ?
                                       CNT_FULL : {1'b0, num_psum};
                        issued_r    <= CNT_ZERO;
                        written_r   <= CNT_ZERO;
                        state_r     <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (ready_to_get) begin
                        flag_r  <= 1'b1;
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_s) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    flag_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef PSUM_DRAIN_SUM_EN
    logic [DATA_W-1:0] sum_r;

    // Running sum of written psums, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= {DATA_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            sum_r <= {DATA_W{1'b0}};
        end else if (wen_s) begin
            sum_r <= sum_r + hold_r;
        end
    end

    assign sum_out = sum_r;
`endif

    assign outbuf_ren        = ren_s;
    assign inpsum_buf_wen    = wen_s;
    assign inpsum_buf_inval  = hold_r;
    assign outbuf_write_flag = flag_r;
    assign busy              = (state_r != IDLE);
    assign done              = (state_r == DONE);

endmodule
